// File: rtl/count_ctrl_pkg.sv
// Shared constants and types for the count_ctrl button/auto-run step controller.
package count_ctrl_pkg;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    CHK_HI = 2'd1,
    S_HI   = 2'd2,
    CHK_LO = 2'd3
  } db_state_t;

endpackage

// File: rtl/count_ctrl_debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM for one raw button.
// level is high while the debounced state is S_HI; press marks the cycle that enters it.
module debounce
  import count_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_cnt_done;

  assign w_cnt_done = (r_cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= S_LO;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter only runs in the CHK states; any disagreeing sample clears it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_LO: begin
        if (r_sync2) w_state_nxt = CHK_HI;
      end
      CHK_HI: begin
        if (!r_sync2)        w_state_nxt = S_LO;
        else if (w_cnt_done) w_state_nxt = S_HI;
        else                 w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_HI: begin
        if (!r_sync2) w_state_nxt = CHK_LO;
      end
      CHK_LO: begin
        if (r_sync2)         w_state_nxt = S_HI;
        else if (w_cnt_done) w_state_nxt = S_LO;
        else                 w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = S_LO;
    endcase
  end

  always_comb begin
    level = (r_state == S_HI);
    press = (r_state == CHK_HI) && (w_state_nxt == S_HI);
  end

endmodule

// File: rtl/count_ctrl.sv
// Up/down step controller: debounced buttons produce one-cycle enable pulses with direction ud.
// Optional periodic stepping is compiled in with macro COUNT_CTRL_AUTORUN_EN.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 250000,
  parameter int CLK_DIV   = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_dn,
  input  logic auto_run,
  output logic ud,
  output logic enable
);

  logic w_up_lvl, w_up_press;
  logic w_dn_lvl, w_dn_press;
  logic w_man_up, w_man_dn, w_man;
  logic w_tick;
  logic w_fire;
  logic r_enable;
  logic r_ud;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clock (clock),
    .reset (reset),
    .din   (btn_up),
    .level (w_up_lvl),
    .press (w_up_press)
  );

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clock (clock),
    .reset (reset),
    .din   (btn_dn),
    .level (w_dn_lvl),
    .press (w_dn_press)
  );

  // Simultaneous presses cancel; a press while the other button is held is ignored.
  assign w_man_up = w_up_press && !w_dn_press && !w_dn_lvl;
  assign w_man_dn = w_dn_press && !w_up_press && !w_up_lvl;
  assign w_man    = w_man_up || w_man_dn;

`ifdef COUNT_CTRL_AUTORUN_EN
  localparam int PW = $clog2(CLK_DIV + 1);

  logic [PW-1:0] r_presc;

  assign w_tick = auto_run && (r_presc == PW'(CLK_DIV - 1));

  // A tick coinciding with a manual pulse still wraps, so the next period starts fresh.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 r_presc <= '0;
    else if (!auto_run || w_tick) r_presc <= '0;
    else                        r_presc <= r_presc + 1'b1;
  end
`else
  logic w_unused;

  assign w_tick   = 1'b0;
  assign w_unused = auto_run & (CLK_DIV > 0);
`endif

  // Back-to-back requests are dropped so enable is never high two cycles running.
  assign w_fire = (w_man || w_tick) && !r_enable;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_enable <= 1'b0;
      r_ud     <= DIR_UP;
    end else begin
      r_enable <= w_fire;
      if (w_man_up && !r_enable)      r_ud <= DIR_UP;
      else if (w_man_dn && !r_enable) r_ud <= DIR_DN;
    end
  end

  assign enable = r_enable;
  assign ud     = r_ud;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl with DB_CYCLES=4, CLK_DIV=8.
module tb_count_ctrl;

  typedef struct packed {
    int   cyc;
    logic ud;
  } exp_t;

  logic clock;
  logic reset;
  logic btn_up;
  logic btn_dn;
  logic auto_run;
  logic ud;
  logic enable;

  int   cyc;
  int   n_vec;
  int   n_err;
  logic prev_en;
  exp_t q[$];

  count_ctrl #(.DB_CYCLES(4), .CLK_DIV(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .auto_run (auto_run),
    .ud       (ud),
    .enable   (enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // Monitor: every enable pulse must match the head of the expectation queue.
  initial prev_en = 1'b0;
  always @(negedge clock) begin
    if (reset && enable) begin
      exp_t e;
      n_vec = n_vec + 1;
      if (prev_en) begin
        n_err = n_err + 1;
        $display("FAIL consecutive_enable cyc=%0d", cyc);
      end else if (q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_pulse cyc=%0d ud=%0b (no pulse expected)", cyc, ud);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.ud !== ud) begin
          n_err = n_err + 1;
          $display("FAIL pulse got cyc=%0d ud=%0b want cyc=%0d ud=%0b", cyc, ud, e.cyc, e.ud);
        end
      end
    end
    prev_en = enable;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_pulse(input int at, input logic d);
    exp_t e;
    e.cyc = at;
    e.ud  = d;
    q.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%0b want=%0b cyc=%0d", name, got, want, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b0;
    btn_up   = 1'b0;
    btn_dn   = 1'b0;
    auto_run = 1'b0;
    wait_cyc(3);
    check_bit("reset_enable", enable, 1'b0);
    check_bit("reset_ud", ud, 1'b0);
    reset = 1'b1;
    wait_cyc(3);

    // Clean up press: pulse 2+4+1 edges after the first sampling edge
    c = cyc;
    btn_up = 1'b1;
    expect_pulse(c + 7, 1'b0);
    wait_cyc(10);
    btn_up = 1'b0;
    wait_cyc(10);
    check_bit("ud_after_up", ud, 1'b0);

    // Bouncing down button never settles for 4 cycles
    for (int i = 0; i < 10; i++) begin
      btn_dn = ~btn_dn;
      wait_cyc(2);
    end
    btn_dn = 1'b0;
    wait_cyc(10);
    check_bit("ud_after_bounce", ud, 1'b0);

    // Simultaneous press cancels
    btn_up = 1'b1;
    btn_dn = 1'b1;
    wait_cyc(10);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_cyc(10);
    check_bit("ud_after_simul", ud, 1'b0);

    // Down press, then up pressed while down still held is ignored
    c = cyc;
    btn_dn = 1'b1;
    expect_pulse(c + 7, 1'b1);
    wait_cyc(10);
    btn_up = 1'b1;
    wait_cyc(10);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_cyc(12);
    check_bit("ud_after_dn", ud, 1'b1);

`ifdef COUNT_CTRL_AUTORUN_EN
    c = cyc;
    auto_run = 1'b1;
    for (int k = 1; k <= 4; k++) expect_pulse(c + 8 * k, 1'b1);
    wait_cyc(32);
    auto_run = 1'b0;
    wait_cyc(10);
    check_bit("ud_after_auto", ud, 1'b1);
`else
    auto_run = 1'b1;
    wait_cyc(40);
    auto_run = 1'b0;
    wait_cyc(5);
    check_bit("ud_after_noauto", ud, 1'b1);
`endif

    // Reset mid-debounce discards progress
    btn_up = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    check_bit("midreset_enable", enable, 1'b0);
    check_bit("midreset_ud", ud, 1'b0);
    wait_cyc(1);
    c = cyc;
    reset = 1'b1;
    expect_pulse(c + 7, 1'b0);
    wait_cyc(12);
    btn_up = 1'b0;
    wait_cyc(12);
    check_bit("ud_after_reset", ud, 1'b0);

    n_vec = n_vec + 1;
    if (q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL missing_pulses got=%0d outstanding want=0 (next cyc=%0d)", q.size(), q[0].cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 250000: consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter CLK_DIV, default 25000000: auto-run tick period in clock cycles.
REQ-003 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port btn_up, input, 1 bit: raw up button, active high, asynchronous to clock.
REQ-006 SHALL have port btn_dn, input, 1 bit: raw down button, active high, asynchronous to clock.
REQ-007 SHALL have port auto_run, input, 1 bit: enables periodic stepping.
REQ-008 SHALL have port ud, output, 1 bit: direction to the downstream counter (0 = up, 1 = down).
REQ-009 SHALL have port enable, output, 1 bit: one-cycle step pulse to the downstream counter.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-011 SHALL run a per-button debounce FSM with states S_LO, CHK_HI, S_HI and CHK_LO.
- S_LO -> CHK_HI when the synced input is 1.
- CHK_HI -> S_HI after DB_CYCLES consecutive synced-1 cycles.
- CHK_HI -> S_LO on any synced 0, with the stability counter cleared.
- S_HI / CHK_LO behave symmetrically for release.
REQ-012 SHALL treat a press event as the cycle in which the debounced level enters S_HI.
REQ-013 SHALL, on an up press event while the down button is not in S_HI, assert enable for exactly one cycle and drive ud=0 in that same cycle.
- enable rises on the clock edge after the press event.
REQ-014 SHALL handle a down press event symmetrically, driving ud=1.
REQ-015 SHALL ignore both events when up and down press events occur in the same cycle: no pulse, ud unchanged.
REQ-016 SHALL ignore a press event whose opposite button is already in S_HI.
REQ-017 SHALL hold ud registered at its last value between pulses.
REQ-018 SHALL never assert enable for two consecutive cycles.
REQ-019 SHALL keep the prescaler counter at 0 whenever auto_run=0.
REQ-020 SHALL, while auto_run=1, increment the prescaler counter each cycle.
- At count CLK_DIV-1, the counter wraps to 0 and a one-cycle enable is issued with the current ud.
REQ-021 SHALL resolve a manual pulse and an auto tick falling in the same cycle as a single pulse with the manual direction, restarting the prescaler at 0.

Reset
REQ-022 SHALL, while reset=0, drive enable=0 and ud=0.
REQ-023 SHALL, while reset=0, place both debouncers in S_LO, clear their stability counters, clear the prescaler and clear the synchronizer flops.
REQ-024 SHALL discard any partial debounce or prescale progress on reset assertion mid-operation.
- The first pulse after release requires full DB_CYCLES or CLK_DIV again.

Configuration
REQ-025 SHALL compile in the prescaler and auto-run behaviour (REQ-019..021) only when macro COUNT_CTRL_AUTORUN_EN is defined.
REQ-026 SHALL, when COUNT_CTRL_AUTORUN_EN is undefined, keep port auto_run but ignore it, include no prescaler logic, and produce enable only from manual presses.

Structure
REQ-027 SHALL place in package count_ctrl_pkg the DIR_UP=1'b0 / DIR_DN=1'b1 constants and the debounce state typedef (S_LO, CHK_HI, S_HI, CHK_LO).
REQ-028 SHALL implement the synchronizer plus debounce FSM as sub-module debounce, instantiated twice.
- debounce has parameter DB_CYCLES and outputs level and press.

Verification (DB_CYCLES=4, CLK_DIV=8)
REQ-029 SHALL verify clean press: btn_up held 10 cycles -> exactly one enable pulse with ud=0, 2+4+1 cycles after the rising edge.
REQ-030 SHALL verify bounce rejection: btn_dn toggling every 2 cycles for 20 cycles, then low -> no enable pulse, ud unchanged.
REQ-031 SHALL verify simultaneous press: btn_up and btn_dn rising on the same edge and held 10 cycles -> no pulse, ud stays 0.
REQ-032 SHALL verify auto-run (macro defined): after a down press, auto_run=1 for 32 cycles -> 4 pulses spaced 8 cycles apart, all with ud=1.
REQ-033 SHALL verify reset mid-debounce: btn_up high, reset pulsed low at cycle 3, button held -> pulse only 7 cycles after reset release, enable=0 and ud=0 during reset.
REQ-034 SHALL verify build without the macro: auto_run=1 for 40 cycles with no button activity -> no enable pulse.
